// File: rtl/spu_result_writeback_pipe_if.sv
// Result writeback bundle: execute-side result insertion, decode-side bypass reads,
// register-file write port and error pulses.
interface spu_result_writeback_pipe_if #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned LAT_W  = 3
);
    logic              res_valid_in;
    logic [DATA_W-1:0] res_data_in;
    logic [ADDR_W-1:0] res_addr_in;
    logic [LAT_W-1:0]  res_lat_in;

    logic [ADDR_W-1:0] rd_addr1_in;
    logic [ADDR_W-1:0] rd_addr2_in;
    logic [ADDR_W-1:0] rd_addr3_in;

    logic [DATA_W-1:0] fwd_data1_out;
    logic [DATA_W-1:0] fwd_data2_out;
    logic [DATA_W-1:0] fwd_data3_out;
    logic              fwd_hit1_out;
    logic              fwd_hit2_out;
    logic              fwd_hit3_out;

    logic              rf_we_out;
    logic [ADDR_W-1:0] rf_waddr_out;
    logic [DATA_W-1:0] rf_wdata_out;

    logic              err_collision_out;
    logic              err_latency_out;

    modport master (
        output res_valid_in, res_data_in, res_addr_in, res_lat_in,
        output rd_addr1_in, rd_addr2_in, rd_addr3_in,
        input  fwd_data1_out, fwd_data2_out, fwd_data3_out,
        input  fwd_hit1_out, fwd_hit2_out, fwd_hit3_out,
        input  rf_we_out, rf_waddr_out, rf_wdata_out,
        input  err_collision_out, err_latency_out
    );

    modport slave (
        input  res_valid_in, res_data_in, res_addr_in, res_lat_in,
        input  rd_addr1_in, rd_addr2_in, rd_addr3_in,
        output fwd_data1_out, fwd_data2_out, fwd_data3_out,
        output fwd_hit1_out, fwd_hit2_out, fwd_hit3_out,
        output rf_we_out, rf_waddr_out, rf_wdata_out,
        output err_collision_out, err_latency_out
    );
endinterface

// File: rtl/spu_result_writeback_pipe.sv
// SPU result return path: latency-tagged results ride a shift pipe to the register
// file write port, with a three-port youngest-writer-wins forwarding bypass.
module spu_result_writeback_pipe #(
    parameter int unsigned DEPTH  = 7,
    parameter int unsigned DATA_W = 128,
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned LAT_W  = 3
) (
    input logic                  clk,
    input logic                  reset,
    spu_result_writeback_pipe_if.slave wb
);
    localparam int unsigned NUM_RD = 3;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } stage_t;

    stage_t            stage_q [DEPTH];
    stage_t            stage_d [DEPTH];
    logic [DEPTH-1:0]  tgt_sel;
    logic              ins_ok;
    logic              col_d;
    logic              col_q;
    logic              lat_err_d;
    logic              lat_err_q;

    logic [ADDR_W-1:0] rd_addr  [NUM_RD];
    logic [DATA_W-1:0] fwd_data [NUM_RD];
    logic [NUM_RD-1:0] fwd_hit;

    // One-hot target stage; no bit set means the latency tag is out of range.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            tgt_sel[k] = (32'(wb.res_lat_in) == (DEPTH - 32'(k)));
        end
        ins_ok    = wb.res_valid_in & (|tgt_sel);
        lat_err_d = wb.res_valid_in & ~(|tgt_sel);
    end

    // Shift every stage down one; the new result overwrites whatever shifts into its slot.
    always_comb begin
        col_d      = 1'b0;
        stage_d[0] = '0;
        for (int k = 1; k < DEPTH; k++) begin
            stage_d[k] = stage_q[k-1];
        end
        for (int k = 0; k < DEPTH; k++) begin
            if (ins_ok && tgt_sel[k]) begin
                col_d            = stage_d[k].valid;
                stage_d[k].valid = 1'b1;
                stage_d[k].addr  = wb.res_addr_in;
                stage_d[k].data  = wb.res_data_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_q[k] <= '0;
            end
            col_q     <= 1'b0;
            lat_err_q <= 1'b0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_q[k] <= stage_d[k];
            end
            col_q     <= col_d;
            lat_err_q <= lat_err_d;
        end
    end

    assign rd_addr[0] = wb.rd_addr1_in;
    assign rd_addr[1] = wb.rd_addr2_in;
    assign rd_addr[2] = wb.rd_addr3_in;

    // Scan oldest to youngest so the lowest-index (latest) writer is the final assignment.
    always_comb begin
        for (int p = 0; p < NUM_RD; p++) begin
            fwd_hit[p]  = 1'b0;
            fwd_data[p] = '0;
            for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
                if (stage_q[k].valid && (stage_q[k].addr == rd_addr[p])) begin
                    fwd_hit[p]  = 1'b1;
                    fwd_data[p] = stage_q[k].data;
                end
            end
        end
    end

    assign wb.fwd_hit1_out  = fwd_hit[0];
    assign wb.fwd_hit2_out  = fwd_hit[1];
    assign wb.fwd_hit3_out  = fwd_hit[2];
    assign wb.fwd_data1_out = fwd_data[0];
    assign wb.fwd_data2_out = fwd_data[1];
    assign wb.fwd_data3_out = fwd_data[2];

    assign wb.rf_we_out    = stage_q[DEPTH-1].valid;
    assign wb.rf_waddr_out = stage_q[DEPTH-1].addr;
    assign wb.rf_wdata_out = stage_q[DEPTH-1].data;

    assign wb.err_collision_out = col_q;
    assign wb.err_latency_out   = lat_err_q;
endmodule
